// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Definitions shared by the ALU sequencer and its flag generator:
//   op_e      - 3-bit ALU/sequencer opcodes (OP_ADD .. OP_ILL)
//   state_e   - sequencer state encoding (IDLE/EXEC/MUL/DONE)
//   FLAG_*    - bit positions of C/Z/N/V inside a packed flag vector
// ---------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_MUL = 3'b110,
    OP_ILL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int NUM_FLAGS = 4;
  localparam int FLAG_C    = 0;
  localparam int FLAG_Z    = 1;
  localparam int FLAG_N    = 2;
  localparam int FLAG_V    = 3;

endpackage

// File: rtl/alu_flag_gen.sv
// ---------------------------------------------------------------------------
// alu_flag_gen
// Combinational C/Z/N/V generation for the single-cycle (non-multiply) ops.
// Ports:
//   op        - opcode being executed
//   a, b      - operands presented to the ALU
//   alu_res   - ALU result
//   alu_cout  - ALU carry out (meaningful for add)
//   alu_bout  - ALU borrow out (meaningful for sub)
//   flags     - packed flags, indexed by alu_pkg::FLAG_*
// ---------------------------------------------------------------------------
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  op_e                  op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     alu_res,
  input  logic                 alu_cout,
  input  logic                 alu_bout,
  output logic [NUM_FLAGS-1:0] flags
);

  logic a_msb, b_msb, r_msb;

  assign a_msb = a[WIDTH-1];
  assign b_msb = b[WIDTH-1];
  assign r_msb = alu_res[WIDTH-1];

  // NOTE: every output of a combinational block gets a default before any
  // branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    flags         = '0;
    flags[FLAG_Z] = (alu_res == '0);
    flags[FLAG_N] = r_msb;
    unique case (op)
      OP_ADD: begin
        flags[FLAG_C] = alu_cout;
        // Overflow: like-signed operands producing an opposite-signed sum.
        flags[FLAG_V] = (a_msb == b_msb) && (r_msb != a_msb);
      end
      OP_SUB: begin
        flags[FLAG_C] = alu_bout;
        // Overflow: differently-signed operands where the sign flips from a.
        flags[FLAG_V] = (a_msb != b_msb) && (r_msb != a_msb);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
// Sequences a shared combinational ALU: one request at a time, registered
// result and C/Z/N/V flags, plus an optional shift-add unsigned multiply that
// reuses the ALU adder once per operand bit.
// Build option: define ALU_OP_SEQUENCER_MUL_EN to enable op 110 (multiply);
// without it op 110 is answered as illegal.
// Ports:
//   clk, rst               - rising-edge clock, synchronous active-high reset
//   start, op, a, b        - request (sampled only while idle)
//   alu_res/cout/bout      - combinational return from the ALU
//   alu_sel, alu_a, alu_b  - ALU drive (zero when idle or done)
//   busy                   - high whenever not idle
//   done                   - one-cycle completion pulse
//   res, res_hi            - result (res_hi: multiply high half, else 0)
//   flag_c/z/n/v, err      - status flags; err marks an illegal opcode
// ---------------------------------------------------------------------------
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_cout,
  input  logic             alu_bout,
  output logic [2:0]       alu_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] res_hi,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v,
  output logic             err
);

  state_e           state;
  op_e              op_q;
  op_e              op_in;
  logic [WIDTH-1:0] a_q, b_q;
  logic [NUM_FLAGS-1:0] exec_flags;

  assign op_in = op_e'(op);

  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .alu_res  (alu_res),
    .alu_cout (alu_cout),
    .alu_bout (alu_bout),
    .flags    (exec_flags)
  );

`ifdef ALU_OP_SEQUENCER_MUL_EN
  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo;
  logic [WIDTH-1:0] nxt_hi, nxt_lo;

  // One shift-add step: add a_q into the high half when the current
  // multiplier bit is set, then shift the whole accumulator right by one.
  always_comb begin
    if (acc_lo[0]) {nxt_hi, nxt_lo} = {alu_cout, alu_res, acc_lo[WIDTH-1:1]};
    else           {nxt_hi, nxt_lo} = {1'b0, acc_hi, acc_lo[WIDTH-1:1]};
  end
`endif

  // NOTE: state and outputs use non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and covers every register here; there are
    // no memory arrays, so nothing is left to power up undefined.
    if (rst) begin
      state   <= ST_IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      alu_sel <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      res     <= '0;
      res_hi  <= '0;
      flag_c  <= 1'b0;
      flag_z  <= 1'b0;
      flag_n  <= 1'b0;
      flag_v  <= 1'b0;
      err     <= 1'b0;
`ifdef ALU_OP_SEQUENCER_MUL_EN
      cnt     <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            op_q <= op_in;
            a_q  <= a;
            b_q  <= b;
            busy <= 1'b1;
`ifdef ALU_OP_SEQUENCER_MUL_EN
            if (op_in == OP_MUL) begin
              // ALU drive for the first step: acc_hi (=0) + a.
              alu_sel <= OP_ADD;
              alu_a   <= '0;
              alu_b   <= a;
              acc_hi  <= '0;
              acc_lo  <= b;
              cnt     <= '0;
              state   <= ST_MUL;
            end else
`endif
            if (op_in == OP_ILL || op_in == OP_MUL) begin
              res    <= '0;
              res_hi <= '0;
              flag_c <= 1'b0;
              flag_z <= 1'b0;
              flag_n <= 1'b0;
              flag_v <= 1'b0;
              err    <= 1'b1;
              done   <= 1'b1;
              state  <= ST_DONE;
            end else begin
              // Drive registered so the ALU sees stable operands in EXEC.
              alu_sel <= op;
              alu_a   <= a;
              alu_b   <= b;
              state   <= ST_EXEC;
            end
          end
        end

        ST_EXEC: begin
          res     <= alu_res;
          res_hi  <= '0;
          flag_c  <= exec_flags[FLAG_C];
          flag_z  <= exec_flags[FLAG_Z];
          flag_n  <= exec_flags[FLAG_N];
          flag_v  <= exec_flags[FLAG_V];
          err     <= 1'b0;
          alu_sel <= '0;
          alu_a   <= '0;
          alu_b   <= '0;
          done    <= 1'b1;
          state   <= ST_DONE;
        end

`ifdef ALU_OP_SEQUENCER_MUL_EN
        ST_MUL: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          cnt    <= cnt + 1'b1;
          // alu_a tracks the accumulator high half for the next step.
          alu_a  <= nxt_hi;
          if (cnt == CW'(WIDTH - 1)) begin
            res     <= nxt_lo;
            res_hi  <= nxt_hi;
            flag_c  <= (nxt_hi != '0);
            flag_z  <= ({nxt_hi, nxt_lo} == '0);
            flag_n  <= 1'b0;
            flag_v  <= 1'b0;
            err     <= 1'b0;
            alu_sel <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            done    <= 1'b1;
            state   <= ST_DONE;
          end
        end
`endif

        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_op_sequencer
// Self-checking bench for alu_op_sequencer (WIDTH=4) with a behavioural ALU
// and a behavioural result model. Multiply expectations follow the
// ALU_OP_SEQUENCER_MUL_EN build option.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_op_sequencer;

  localparam int W    = 4;
  localparam int MAXC = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic [W-1:0] alu_res;
  logic         alu_cout, alu_bout;
  logic [2:0]   alu_sel;
  logic [W-1:0] alu_a, alu_b;
  logic         busy, done;
  logic [W-1:0] res, res_hi;
  logic         flag_c, flag_z, flag_n, flag_v, err;

  int checks   = 0;
  int failures = 0;

`ifdef ALU_OP_SEQUENCER_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .alu_res  (alu_res),
    .alu_cout (alu_cout),
    .alu_bout (alu_bout),
    .alu_sel  (alu_sel),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .busy     (busy),
    .done     (done),
    .res      (res),
    .res_hi   (res_hi),
    .flag_c   (flag_c),
    .flag_z   (flag_z),
    .flag_n   (flag_n),
    .flag_v   (flag_v),
    .err      (err)
  );

  // Behavioural shared ALU.
  always_comb begin
    int s;
    s        = 0;
    alu_cout = 1'b0;
    alu_bout = 1'b0;
    case (alu_sel)
      3'b000: begin s = int'(alu_a) + int'(alu_b); alu_cout = (s >= 16); end
      3'b001: begin s = int'(alu_a) - int'(alu_b); alu_bout = (alu_a < alu_b); end
      3'b010: s = int'(alu_a & alu_b);
      3'b011: s = int'(alu_a | alu_b);
      3'b100: s = int'(alu_a ^ alu_b);
      3'b101: s = int'(~alu_a);
      default: s = 0;
    endcase
    alu_res = W'(s & 15);
  end

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic [W-1:0] res, res_hi;
    logic         c, z, n, v, err;
    int           lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int sgn(input logic [W-1:0] x);
    return x[W-1] ? int'(x) - 16 : int'(x);
  endfunction

  // Expected behaviour from plain arithmetic on the operands.
  function automatic vec_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    vec_t e;
    int r, s;
    e = '{op: o, a: x, b: y, res: 0, res_hi: 0, c: 0, z: 0, n: 0, v: 0, err: 0, lat: 2};
    r = 0;
    case (o)
      3'd0: begin r = int'(x) + int'(y); e.c = (r > 15); s = sgn(x) + sgn(y); e.v = (s > 7 || s < -8); end
      3'd1: begin r = int'(x) - int'(y); e.c = (x < y);  s = sgn(x) - sgn(y); e.v = (s > 7 || s < -8); end
      3'd2: r = int'(x & y);
      3'd3: r = int'(x | y);
      3'd4: r = int'(x ^ y);
      3'd5: r = 15 - int'(x);
      default: r = 0;
    endcase
    if (o == 3'd6 && MUL_EN) begin
      r        = int'(x) * int'(y);
      e.res    = W'(r % 16);
      e.res_hi = W'(r / 16);
      e.c      = (r >= 16);
      e.z      = (r == 0);
      e.lat    = W + 1;
    end else if (o >= 3'd6) begin
      e.err = 1'b1;
      e.lat = 1;
    end else begin
      e.res = W'(r & 15);
      e.z   = (e.res == 0);
      e.n   = e.res[W-1];
    end
    return e;
  endfunction

  // Issue one op from IDLE and check latency, pulse shape and results.
  task automatic run_op(input vec_t e, input string tag);
    int dcyc;
    @(negedge clk);
    start = 1'b1; op = e.op; a = e.a; b = e.b;
    dcyc = 0;
    for (int cyc = 1; cyc <= MAXC && dcyc == 0; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (cyc == 1) check({tag, " busy_c1"}, 32'(busy), 1);
      if (e.op == 3'd6 && MUL_EN && cyc <= W) check({tag, " mul_sel"}, 32'(alu_sel), 0);
      if (done) dcyc = cyc;
    end
    if (dcyc == 0) begin
      check({tag, " timeout"}, 0, 1);
      return;
    end
    check({tag, " latency"}, 32'(dcyc), 32'(e.lat));
    check({tag, " res"},     32'(res), 32'(e.res));
    check({tag, " res_hi"},  32'(res_hi), 32'(e.res_hi));
    check({tag, " flags"},   {28'd0, flag_c, flag_z, flag_n, flag_v},
                             {28'd0, e.c, e.z, e.n, e.v});
    check({tag, " err"},     32'(err), 32'(e.err));
    @(negedge clk);
    check({tag, " done_1c"}, 32'(done), 0);
    check({tag, " busy_end"}, 32'(busy), 0);
  endtask

  vec_t vecs[$];
  vec_t e;
  int   seen;

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset outs", {16'd0, 3'(alu_sel), busy, done, res, res_hi, flag_c, flag_z, flag_n, flag_v, err}, 0);
    check("reset alu_ab", {24'd0, alu_a, alu_b}, 0);
    rst = 1'b0;

    // Directed vectors with hand-derived expectations.
    vecs.push_back('{3'd0, 4'd9,  4'd8,  4'h1, 4'h0, 1, 0, 0, 1, 0, 2});
    vecs.push_back('{3'd1, 4'd3,  4'd5,  4'hE, 4'h0, 1, 0, 1, 0, 0, 2});
    vecs.push_back('{3'd0, 4'd7,  4'd1,  4'h8, 4'h0, 0, 0, 1, 1, 0, 2});
    vecs.push_back('{3'd1, 4'd8,  4'd1,  4'h7, 4'h0, 0, 0, 0, 1, 0, 2});
    vecs.push_back('{3'd2, 4'hC,  4'hA,  4'h8, 4'h0, 0, 0, 1, 0, 0, 2});
    vecs.push_back('{3'd3, 4'h0,  4'h0,  4'h0, 4'h0, 0, 1, 0, 0, 0, 2});
    vecs.push_back('{3'd4, 4'hF,  4'hF,  4'h0, 4'h0, 0, 1, 0, 0, 0, 2});
    vecs.push_back('{3'd5, 4'h5,  4'h0,  4'hA, 4'h0, 0, 0, 1, 0, 0, 2});
    vecs.push_back('{3'd7, 4'h6,  4'h3,  4'h0, 4'h0, 0, 0, 0, 0, 1, 1});
`ifdef ALU_OP_SEQUENCER_MUL_EN
    vecs.push_back('{3'd6, 4'd13, 4'd11, 4'hF, 4'h8, 1, 0, 0, 0, 0, 5});
    vecs.push_back('{3'd6, 4'd0,  4'd5,  4'h0, 4'h0, 0, 1, 0, 0, 0, 5});
    vecs.push_back('{3'd6, 4'd15, 4'd15, 4'h1, 4'hE, 1, 0, 0, 0, 0, 5});
`else
    vecs.push_back('{3'd6, 4'd13, 4'd11, 4'h0, 4'h0, 0, 0, 0, 0, 1, 1});
`endif
    foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

    // Random ops against the model.
    for (int i = 0; i < 150; i++) begin
      e = model(3'($urandom_range(7)), 4'($urandom_range(15)), 4'($urandom_range(15)));
      run_op(e, $sformatf("rnd%0d op%0d", i, e.op));
    end

    // start while busy is ignored: no second done, result untouched.
    @(negedge clk);
    start = 1'b1; op = MUL_EN ? 3'd6 : 3'd0; a = MUL_EN ? 4'd13 : 4'd3; b = MUL_EN ? 4'd11 : 4'd4;
    @(posedge clk); @(negedge clk);
    start = 1'b1; op = 3'd0; a = 4'd1; b = 4'd1;          // arrives in cycle 1
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int cyc = 2; cyc <= 12; cyc++) begin
      if (done) begin
        seen++;
        check("busy_start res", 32'(res), MUL_EN ? 32'hF : 32'h7);
        check("busy_start res_hi", 32'(res_hi), MUL_EN ? 32'h8 : 32'h0);
      end
      @(posedge clk); @(negedge clk);
    end
    check("busy_start done_count", 32'(seen), 1);
    check("busy_start idle", 32'(busy), 0);

    // Reset in the second MUL cycle (EXEC cycle when MUL is disabled).
    @(negedge clk);
    start = 1'b1; op = MUL_EN ? 3'd6 : 3'd0; a = 4'd13; b = 4'd11;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    if (MUL_EN) begin
      @(posedge clk); @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check("midrst busy", 32'(busy), 0);
    check("midrst outs", {19'd0, done, res, res_hi, flag_c, flag_z, flag_n, flag_v, err}, 0);
    check("midrst alu_sel", 32'(alu_sel), 0);
    run_op('{3'd0, 4'd1, 4'd1, 4'h2, 4'h0, 0, 0, 0, 0, 0, 2}, "post_rst add");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
